// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide execute unit.
// A single 2*XLEN shift register is shared by the shift-add multiplier
// (upper half = partial sum, lower half = remaining multiplier bits) and the
// restoring divider (upper half = partial remainder, lower half = quotient).
// The write-back bundle is registered and presented for one cycle after the
// internal DONE state, which gives XLEN+2 edges of latency from acceptance.
module muldiv_unit #(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [4:0]      write_reg,
   output logic [XLEN-1:0] write_data,
   output logic            regwrite
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        r_state;
   logic [CW-1:0]     r_cnt;
   logic [2:0]        r_op;
   logic [4:0]        r_rd;
   logic              r_neg_a;
   logic              r_neg_b;
   logic [XLEN-1:0]   r_opb;
   logic [2*XLEN-1:0] r_prod;
   logic [XLEN-1:0]   r_result;
   logic              r_done;
   logic              r_regwrite;
   logic [4:0]        r_wreg;
   logic [XLEN-1:0]   r_wdata;

   logic              w_a_signed, w_b_signed, w_neg_a, w_neg_b;
   logic [XLEN-1:0]   w_mag_a, w_mag_b;
   logic              w_div_zero, w_div_ovf, w_special;
   logic [XLEN-1:0]   w_special_res;
   logic [XLEN:0]     w_add, w_shift, w_diff;
   logic              w_ge;
   logic [2*XLEN-1:0] w_mul_next, w_div_next, w_prod_s;
   logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;
   logic              w_accept;

   // Operand decode at acceptance: signedness, magnitudes and special divides
   always_comb begin
      w_a_signed    = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                      (op == 3'b100) || (op == 3'b110);
      w_b_signed    = (op == 3'b000) || (op == 3'b001) ||
                      (op == 3'b100) || (op == 3'b110);
      w_neg_a       = w_a_signed && rs1_data[XLEN-1];
      w_neg_b       = w_b_signed && rs2_data[XLEN-1];
      w_mag_a       = w_neg_a ? (~rs1_data + 1'b1) : rs1_data;
      w_mag_b       = w_neg_b ? (~rs2_data + 1'b1) : rs2_data;
      w_div_zero    = op[2] && (rs2_data == '0);
      w_div_ovf     = op[2] && !op[0] && (rs1_data == MOST_NEG) && (rs2_data == '1);
      w_special     = w_div_zero || w_div_ovf;
      // Divide by zero wins when both could apply (it cannot: B=-1 is nonzero)
      if (w_div_zero)
         w_special_res = op[1] ? rs1_data : '1;
      else
         w_special_res = op[1] ? '0 : MOST_NEG;
      w_accept      = (r_state == S_IDLE) && !r_done && start;
   end

   // One radix-2 step of the shared datapath and the final sign fix-up
   always_comb begin
      w_add      = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_opb} : '0);
      w_mul_next = {w_add, r_prod[XLEN-1:1]};
      w_shift    = r_prod[2*XLEN-1:XLEN-1];
      w_diff     = w_shift - {1'b0, r_opb};
      w_ge       = !w_diff[XLEN];
      w_div_next = {(w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]), r_prod[XLEN-2:0], w_ge};
      w_prod_s   = (r_neg_a ^ r_neg_b) ? (~r_prod + 1'b1) : r_prod;
      w_quo      = (r_neg_a ^ r_neg_b) ? (~r_prod[XLEN-1:0] + 1'b1) : r_prod[XLEN-1:0];
      w_rem      = r_neg_a ? (~r_prod[2*XLEN-1:XLEN] + 1'b1) : r_prod[2*XLEN-1:XLEN];
      if (r_op[2])
         w_fix_res = r_op[1] ? w_rem : w_quo;
      else
         w_fix_res = (r_op[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
   end

   // Control FSM, datapath registers and the registered write-back bundle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_op       <= '0;
         r_rd       <= '0;
         r_neg_a    <= 1'b0;
         r_neg_b    <= 1'b0;
         r_opb      <= '0;
         r_prod     <= '0;
         r_result   <= '0;
         r_done     <= 1'b0;
         r_regwrite <= 1'b0;
         r_wreg     <= '0;
         r_wdata    <= '0;
      end else begin
         r_done     <= 1'b0;
         r_regwrite <= 1'b0;
         if (kill && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     r_op     <= op;
                     r_rd     <= rd;
                     r_neg_a  <= w_neg_a;
                     r_neg_b  <= w_neg_b;
                     r_opb    <= w_mag_b;
                     r_prod   <= {{XLEN{1'b0}}, w_mag_a};
                     r_result <= w_special_res;
                     r_cnt    <= '0;
                     r_state  <= w_special ? S_DONE : S_CALC;
                  end
               end
               S_CALC: begin
                  r_prod <= r_op[2] ? w_div_next : w_mul_next;
                  r_cnt  <= r_cnt + 1'b1;
                  if (r_cnt == LAST_STEP)
                     r_state <= S_FIX;
               end
               S_FIX: begin
                  r_result <= w_fix_res;
                  r_state  <= S_DONE;
               end
               default: begin
                  r_done     <= 1'b1;
                  r_regwrite <= (r_rd != 5'd0);
                  r_wreg     <= r_rd;
                  r_wdata    <= r_result;
                  r_state    <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign busy       = (r_state != S_IDLE) || r_done;
   assign done       = r_done;
   assign regwrite   = r_regwrite;
   assign write_reg  = r_wreg;
   assign write_data = r_wdata;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model (wide multiplies, native / and %).
module tb_muldiv_unit;

   localparam int XLEN = 64;
   localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic [2:0]      op = '0;
   logic [XLEN-1:0] rs1_data = '0;
   logic [XLEN-1:0] rs2_data = '0;
   logic [4:0]      rd = '0;
   logic            kill = 1'b0;
   logic            busy, done, regwrite;
   logic [4:0]      write_reg;
   logic [XLEN-1:0] write_data;

   int n_cmp = 0;
   int n_bad = 0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd), .kill(kill),
      .busy(busy), .done(done), .write_reg(write_reg),
      .write_data(write_data), .regwrite(regwrite)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] sa, sb, sp;
      logic [127:0]        up;
      logic signed [63:0]  a64, b64;
      logic                ovf;
      a64 = a;
      b64 = b;
      ovf = (a == MOST_NEG) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
      model = '0;
      case (f)
         3'd0: model = a * b;
         3'd1: begin sa = {{64{a[63]}}, a}; sb = {{64{b[63]}}, b}; sp = sa * sb; model = sp[127:64]; end
         3'd2: begin sa = {{64{a[63]}}, a}; sb = {64'd0, b};       sp = sa * sb; model = sp[127:64]; end
         3'd3: begin up = {64'd0, a} * {64'd0, b}; model = up[127:64]; end
         3'd4: model = (b == 0) ? '1 : ovf ? MOST_NEG : 64'(a64 / b64);
         3'd5: model = (b == 0) ? '1 : a / b;
         3'd6: model = (b == 0) ? a : ovf ? 64'd0 : 64'(a64 % b64);
         default: model = (b == 0) ? a : a % b;
      endcase
   endfunction

   // Issue one operation and check the write-back bundle and its latency.
   // disturb=1 pulses start with other operands at edge 10 after acceptance.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] dst, input bit disturb);
      int n;
      int exp_lat;
      logic [63:0] exp;
      exp = model(f, a, b);
      exp_lat = (f[2] && ((b == 0) || (!f[0] && a == MOST_NEG && b == '1))) ? 1 : XLEN + 2;
      @(negedge clock);
      op = f; rs1_data = a; rs2_data = b; rd = dst; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check_eq({tag, "_busy"}, 64'(busy), 64'd1);
      n = 0;
      do begin
         if (disturb && n == 9) begin
            start = 1'b1; op = 3'd0; rs1_data = 64'd1234; rs2_data = 64'd99; rd = 5'd17;
         end
         if (disturb && n == 10) start = 1'b0;
         @(posedge clock); #1;
         n++;
         if (!done) check_eq({tag, "_rw_idle"}, 64'(regwrite), 64'd0);
      end while (!done && n < 200);
      check_eq({tag, "_lat"}, 64'(n), 64'(exp_lat));
      check_eq({tag, "_data"}, write_data, exp);
      check_eq({tag, "_reg"}, 64'(write_reg), 64'(dst));
      check_eq({tag, "_rw"}, 64'(regwrite), 64'(dst != 5'd0));
      $display("op=%0d a=0x%016h b=0x%016h rd=%0d -> 0x%016h (exp 0x%016h) lat=%0d",
               f, a, b, dst, write_data, exp, n);
      @(posedge clock); #1;
      check_eq({tag, "_done_end"}, 64'(done), 64'd0);
      check_eq({tag, "_busy_end"}, 64'(busy), 64'd0);
      check_eq({tag, "_hold"}, write_data, exp);
   endtask

   function automatic logic [63:0] rand_operand();
      case ($urandom_range(0, 7))
         0: rand_operand = 64'd0;
         1: rand_operand = '1;
         2: rand_operand = MOST_NEG;
         3: rand_operand = 64'($urandom_range(0, 20));
         default: rand_operand = {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      int n;
      bit seen_done;
      // Reset state
      #12;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_data", write_data, 64'd0);
      @(negedge clock); reset = 1'b1;

      // Directed cases
      run_op("mul7x6", 3'd0, 64'd7, 64'd6, 5'd5, 1'b0);
      run_op("mulhu",  3'd3, '1, '1, 5'd1, 1'b0);
      run_op("mulh",   3'd1, '1, '1, 5'd2, 1'b0);
      run_op("mulhsu", 3'd2, '1, 64'd2, 5'd3, 1'b0);
      run_op("div",    3'd4, -64'sd7, 64'd2, 5'd4, 1'b0);
      run_op("rem",    3'd6, -64'sd7, 64'd2, 5'd4, 1'b0);
      run_op("divu",   3'd5, 64'd100, 64'd7, 5'd6, 1'b0);
      run_op("remu",   3'd7, 64'd100, 64'd7, 5'd6, 1'b0);
      run_op("divu0",  3'd5, 64'd100, 64'd0, 5'd7, 1'b0);
      run_op("remu0",  3'd7, 64'd100, 64'd0, 5'd7, 1'b0);
      run_op("divovf", 3'd4, MOST_NEG, '1, 5'd8, 1'b0);
      run_op("removf", 3'd6, MOST_NEG, '1, 5'd8, 1'b0);
      run_op("ignore", 3'd0, 64'd11, 64'd13, 5'd9, 1'b1);
      run_op("rd0",    3'd0, 64'd5, 64'd5, 5'd0, 1'b0);

      // Kill during CALC
      @(negedge clock);
      op = 3'd0; rs1_data = 64'd21; rs2_data = 64'd2; rd = 5'd10; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (30) begin @(posedge clock); #1; end
      kill = 1'b1;
      @(posedge clock); #1;
      kill = 1'b0;
      check_eq("kill_busy", 64'(busy), 64'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clock); #1;
         if (done) seen_done = 1'b1;
      end
      check_eq("kill_nodone", 64'(seen_done), 64'd0);
      $display("kill at edge 31: busy=%0d done_seen=%0d", busy, seen_done);

      // Asynchronous reset mid-CALC
      @(negedge clock);
      op = 3'd0; rs1_data = 64'd8; rs2_data = 64'd8; rd = 5'd11; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (20) begin @(posedge clock); #1; end
      #2 reset = 1'b0;
      #1;
      check_eq("arst_busy", 64'(busy), 64'd0);
      check_eq("arst_data", write_data, 64'd0);
      check_eq("arst_reg", 64'(write_reg), 64'd0);
      check_eq("arst_rw", 64'(regwrite), 64'd0);
      $display("async reset: busy=%0d data=0x%016h", busy, write_data);
      @(negedge clock); reset = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clock); #1;
         if (done) seen_done = 1'b1;
      end
      check_eq("arst_nodone", 64'(seen_done), 64'd0);
      run_op("mul3x3", 3'd0, 64'd3, 64'd3, 5'd12, 1'b0);

      // Randomized operations against the model
      for (int t = 0; t < 40; t++) begin
         n = $urandom_range(0, 7);
         run_op("rand", 3'(n), rand_operand(), rand_operand(), 5'($urandom_range(0, 31)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide execute unit.
- Consumes the two register-file read operands (ReadData1/ReadData2) and the destination index from decode.
- Produces a one-cycle write-back bundle (write_reg, write_data, regwrite) that drives the register file write port directly.
- Uses one shared 64-step shift/add–subtract datapath, so both multiply and divide take a fixed XLEN+2 cycles.

Parameters:
XLEN, 64, operand/result width; iteration count equals XLEN.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
start  input  1  request; sampled only when busy=0.
op  input  3  RV64M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1_data  input  XLEN  operand A (from ReadData1).
rs2_data  input  XLEN  operand B (from ReadData2).
rd  input  5  destination register index.
kill  input  1  synchronous abort of the in-flight operation.
busy  output  1  high from the accepting edge until the done cycle completes.
done  output  1  one-cycle completion pulse.
write_reg  output  5  destination index to register file.
write_data  output  XLEN  result.
regwrite  output  1  register-file write enable; pulses with done only when write_reg != 0.

Behaviour:
Reset:
- While reset=0, all outputs are 0 and state is IDLE, regardless of clock.
- Reset mid-operation discards the operation; no done pulse follows.

FSM states: IDLE, CALC, FIX, DONE.
- IDLE: on an edge with start=1, latch op, operands, and rd; set busy.
  - Special divide case (divisor==0, or DIV/REM with A=most-negative and B=-1): go to DONE.
  - Otherwise go to CALC with step counter = 0.
- CALC: one radix-2 step per cycle; exits to FIX after XLEN steps (counter XLEN-1).
  - Multiply: shift-add on operand magnitudes into a 2*XLEN product.
  - Divide: restoring shift-subtract on magnitudes, producing quotient and remainder.
- FIX: apply signs and select the result; go to DONE.
  - Signedness: MUL/MULH both signed; MULHSU A signed, B unsigned; MULHU both unsigned; DIV/REM signed; DIVU/REMU unsigned.
  - Result select: MUL = product[XLEN-1:0]; MULH* = product[2*XLEN-1:XLEN].
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- DONE: done=1 and write_data/write_reg valid for exactly one cycle; regwrite=(rd!=0); then IDLE with busy=0.

Latency:
- Normal operation: done is high in the cycle beginning XLEN+2 edges after the accepting edge (66 for XLEN=64).
- Special divide case: done after 1 edge.
- Back-to-back: start may be asserted in the DONE cycle but is ignored; it is accepted at the next edge, in IDLE.

Special divide values:
- Divide by zero: quotient = all ones; remainder = dividend. Applies to signed and unsigned.
- Signed overflow: quotient = most-negative value; remainder = 0.

Other boundary rules:
- start while busy=1 is ignored; latched operands are unchanged.
- kill=1 in CALC/FIX/DONE: next edge returns to IDLE with busy=0, done=0, regwrite=0. kill in IDLE has no effect, and kill has priority over start.
- rd=0: the operation completes and done pulses, but regwrite stays 0.
- Outputs are registered: write_data and write_reg hold their last value after done, and regwrite is 0 outside done.

Test Plan:
1. MUL 7×6, rd=5: start at edge 0 → at edge 66, done=1, regwrite=1, write_reg=5, write_data=0x2A for one cycle; busy=0 the next cycle.
2. MULHU 0xFFFFFFFFFFFFFFFF² → 0xFFFFFFFFFFFFFFFE. MULH (-1)×(-1) → 0. MULHSU (-1)×2 → 0xFFFFFFFFFFFFFFFF.
3. Signed divide of -7 by 2:
   - DIV → 0xFFFFFFFFFFFFFFFD (-3).
   - REM → 0xFFFFFFFFFFFFFFFF (-1).
   - DIVU 100/7 → 14; REMU 100/7 → 2.
4. Special divide cases, each with done one edge after accept:
   - DIVU 100/0 → 0xFFFFFFFFFFFFFFFF; REMU 100/0 → 100 (0x64).
   - DIV 0x8000000000000000/-1 → 0x8000000000000000; REM of the same operands → 0.
5. Control flow:
   - start pulsed again at edge 10 with different operands → ignored; the original result is written.
   - MUL with rd=0 → done=1, regwrite=0.
6. Abort:
   - kill at edge 30 → busy=0 at edge 31; no done pulse.
   - reset=0 asserted asynchronously mid-CALC → all outputs 0 immediately.
   - After reset releases, a new MUL 3×3 returns 9.
